view_compositor: RTL
====================

# view_compositor

Parametrised video compositor that merges `NUM_VIEWS` independently rendered view streams into one pixel stream. Each view owns a rectangular screen window, and overlapping windows are resolved by fixed priority. The block sits between the `vga` timing generator plus view renderers (track, racer, forward, and future views) and the VGA output pins. It replaces hard-coded region muxing with run-time window configuration committed atomically at frame start, and it delays sync, blank and counts to match renderer latency.

## Interface
- `NUM_VIEWS`, 4: number of view inputs; 1..8.
- `PIPE_DEPTH`, 6: renderer latency in cycles from `hcount_in`/`vcount_in` to `pixel_in`; must be ≥2.
- `H_W`, 11: hcount width.
- `V_W`, 10: vcount width.
- `PIX_W`, 12: pixel width (RGB444).
- `BG_COLOR`, 12'h000: colour shown where no enabled window hits.
- `clk_in` in 1: pixel clock (eth_refclk domain).
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `hcount_in` in H_W, `vcount_in` in V_W: timing-generator counts.
- `hsync_in`, `vsync_in`, `blank_in` in 1: timing-generator controls, active-high.
- `pixel_in` in NUM_VIEWS×PIX_W: view pixels, aligned PIPE_DEPTH cycles after the counts.
- `cfg_valid_in` in 1, `cfg_ready_out` out 1: window-write handshake.
- `cfg_view_in` in $clog2(NUM_VIEWS) (min 1): window index to write.
- `cfg_en_in` in 1: window enable.
- `cfg_x0_in`, `cfg_x1_in` in H_W; `cfg_y0_in`, `cfg_y1_in` in V_W: window bounds, half-open [x0,x1)×[y0,y1).
- `pixel_out` out PIX_W; `hsync_out`, `vsync_out`, `blank_out` out 1; `hcount_out` out H_W; `vcount_out` out V_W: aligned output stream.
- `sel_view_out` out $clog2(NUM_VIEWS)+1: winning view index, or NUM_VIEWS for background/blank.
- `commit_out` out 1: one-cycle pulse when shadow is copied to active.
- `frame_count_out` out 16: commits since reset; wraps 0xFFFF→0.

## Operation
- Two window tables: shadow (write target) and active (used for selection).
- A config write occurs when `cfg_valid_in && cfg_ready_out`. It updates the shadow entry at `cfg_view_in`. A write with an index ≥NUM_VIEWS is accepted and ignored.
- Commit happens in the cycle after a rising edge of `vsync_in`, detected with a registered previous value. In that cycle:
  - shadow is copied into active;
  - `cfg_ready_out` is held 0, so no write collides with the copy;
  - `commit_out` is 1;
  - `frame_count_out` increments.
- `cfg_ready_out` is 1 in all other cycles.
- Hit test for view i: `en && h>=x0 && h<x1 && v>=y0 && v<y1`, all unsigned. A window with x1≤x0 or y1≤y0 never hits.
- Priority: the lowest hitting index wins. If there is no hit, the selection is NUM_VIEWS (background).
- Output pixel:
  - if delayed blank is 1, output 0;
  - else if the selection is a view, output `pixel_in[sel]`;
  - else output BG_COLOR.
- Sync is passed through in its input polarity; the top level performs inversion.

## Timing
- Pipeline stages:
  - S1 registers the hit vector.
  - S2 registers the priority-encoded selection.
  - A shift register delays the selection to stage PIPE_DEPTH.
  - The output register adds 1 more stage.
- Latency from counts/sync/blank in to all outputs: exactly PIPE_DEPTH+1 cycles. `pixel_out` uses `pixel_in` sampled at stage PIPE_DEPTH.
- A commit takes effect for the count sampled in the cycle after `commit_out`.
- A write accepted in frame N is visible from the first commit after the write.
- Reset values:
  - all outputs and pipe stages 0, except `blank_out`=1, `blank` pipe all 1, and `sel_view_out`=NUM_VIEWS;
  - both tables cleared, with all windows disabled;
  - `cfg_ready_out`=1;
  - `frame_count_out`=0.
- If reset is asserted mid-frame, the pipeline is flushed immediately. The first commit occurs at the next vsync rise after release.
- A `vsync_in` held high does not retrigger a commit; commits fire on the rising edge only.

## Structure
- `compositor_pkg` holds:
  - typedef `window_t` {en, x0, x1, y0, y1}, built from the H_W/V_W defaults;
  - `localparam VIEW_IDX_W`.
- One sub-module, `window_hit`, performs the combinational hit test for one window. It is instantiated NUM_VIEWS times under a generate block.
- The delay lines are inline generate shift registers sized by PIPE_DEPTH.

## Test plan
- Reset, no cfg, 1024×768 timing → `pixel_out`=BG_COLOR in the active region, 0 during blank. `sel_view_out`=4. `hsync_out` equals `hsync_in` delayed 7 cycles.
- Write view0 [0,512)×[0,512), view1 [512,1024)×[0,384), view2 [512,1024)×[384,768), then one vsync rise:
  - at output count (100,100) → `pixel_in[0]`;
  - at (600,200) → view1;
  - at (600,500) → view2;
  - at (100,600) → BG.
- Overlap: view1 and view3 both cover (700,100) → view1 wins. Disable view1 and commit → view3.
- Write issued mid-frame → output unchanged until the cycle after the next `commit_out`. During the commit cycle `cfg_ready_out`=0, and a write held valid is accepted the next cycle.
- Degenerate window x0=x1=300, enabled → never selected. An out-of-range `cfg_view_in` is accepted and changes nothing.
- Assert `rst_n_in` mid-line → outputs reach reset values asynchronously. `frame_count_out`=0. After release, windows stay disabled until the first commit.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types for the view compositor: window descriptor and index widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package compositor_pkg;

  // Window coordinate widths; the compositor's H_W/V_W must match these.
  localparam int WIN_H_W       = 11;
  localparam int WIN_V_W       = 10;
  localparam int DEF_NUM_VIEWS = 4;

  // Width of a selection index that can also encode "background" (== NUM_VIEWS).
  localparam int VIEW_IDX_W = $clog2(DEF_NUM_VIEWS) + 1;

  // Half-open rectangle [x0,x1) x [y0,y1), gated by en.
  typedef struct packed {
    logic               en;
    logic [WIN_H_W-1:0] x0;
    logic [WIN_H_W-1:0] x1;
    logic [WIN_V_W-1:0] y0;
    logic [WIN_V_W-1:0] y1;
  } window_t;

  localparam window_t WINDOW_OFF = '0;

endpackage

// File: rtl/view_compositor_window_hit.sv
// Combinational hit test of one screen position against one window.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: win_i window descriptor, h_i/v_i screen position, hit_o position inside enabled window.
module window_hit
  import compositor_pkg::*;
(
  input  window_t            win_i,
  input  logic [WIN_H_W-1:0] h_i,
  input  logic [WIN_V_W-1:0] v_i,
  output logic               hit_o
);

  // Unsigned half-open compares: x1<=x0 or y1<=y0 can never satisfy both bounds.
  assign hit_o = win_i.en
              && (h_i >= win_i.x0) && (h_i < win_i.x1)
              && (v_i >= win_i.y0) && (v_i < win_i.y1);

endmodule

// File: rtl/view_compositor.sv
// Merges NUM_VIEWS rendered view streams into one pixel stream by per-view window and fixed priority.
// Latency: PIPE_DEPTH+1 cycles from counts/sync/blank to every output.
// Backpressure: cfg_ready_out drops for the single commit cycle after a vsync rise; stream never stalls.
// Ports: clk_in/rst_n_in; timing counts+controls in; pixel_in (view i at bits [i*PIX_W +: PIX_W]);
//        cfg_* window write into shadow table; delayed stream out, sel_view_out, commit_out, frame_count_out.
module view_compositor
  import compositor_pkg::*;
#(
  parameter int               NUM_VIEWS  = 4,
  parameter int               PIPE_DEPTH = 6,
  parameter int               H_W        = 11,
  parameter int               V_W        = 10,
  parameter int               PIX_W      = 12,
  parameter logic [PIX_W-1:0] BG_COLOR   = '0,
  localparam int              CFG_W      = (NUM_VIEWS > 1) ? $clog2(NUM_VIEWS) : 1,
  localparam int              SEL_W      = $clog2(NUM_VIEWS) + 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [H_W-1:0]             hcount_in,
  input  logic [V_W-1:0]             vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       blank_in,
  input  logic [NUM_VIEWS*PIX_W-1:0] pixel_in,
  input  logic                       cfg_valid_in,
  output logic                       cfg_ready_out,
  input  logic [CFG_W-1:0]           cfg_view_in,
  input  logic                       cfg_en_in,
  input  logic [H_W-1:0]             cfg_x0_in,
  input  logic [H_W-1:0]             cfg_x1_in,
  input  logic [V_W-1:0]             cfg_y0_in,
  input  logic [V_W-1:0]             cfg_y1_in,
  output logic [PIX_W-1:0]           pixel_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       blank_out,
  output logic [H_W-1:0]             hcount_out,
  output logic [V_W-1:0]             vcount_out,
  output logic [SEL_W-1:0]           sel_view_out,
  output logic                       commit_out,
  output logic [15:0]                frame_count_out
);

  localparam logic [SEL_W-1:0] SEL_BG = SEL_W'(NUM_VIEWS);

  // ---------------------------------------------------------------------------
  // Frame commit: vsync rise -> one commit cycle -> active table updated.
  // ---------------------------------------------------------------------------
  logic        vsync_prev_q;
  logic        commit_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        vs_rise;

  assign vs_rise = vsync_in && !vsync_prev_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vs_rise) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // vsync_prev resets high so a vsync already high at reset release is not
  // mistaken for a rising edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vsync_prev_q <= 1'b1;
      commit_q     <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vsync_prev_q <= vsync_in;
      commit_q     <= vs_rise;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign commit_out      = commit_q;
  assign frame_count_out = frame_cnt_q;
  // Writes are refused while the shadow is being copied so none is lost or split.
  assign cfg_ready_out   = !commit_q;

  // ---------------------------------------------------------------------------
  // Shadow / active window tables.
  // ---------------------------------------------------------------------------
  window_t shadow_q [NUM_VIEWS];
  window_t active_q [NUM_VIEWS];
  window_t cfg_win;
  logic    cfg_fire;

  assign cfg_fire = cfg_valid_in && cfg_ready_out;

  always_comb begin
    cfg_win    = WINDOW_OFF;
    cfg_win.en = cfg_en_in;
    cfg_win.x0 = WIN_H_W'(cfg_x0_in);
    cfg_win.x1 = WIN_H_W'(cfg_x1_in);
    cfg_win.y0 = WIN_V_W'(cfg_y0_in);
    cfg_win.y1 = WIN_V_W'(cfg_y1_in);
  end

  // An index >= NUM_VIEWS matches no entry, so such writes are accepted and dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_VIEWS; i++) begin
        shadow_q[i] <= WINDOW_OFF;
        active_q[i] <= WINDOW_OFF;
      end
    end else begin
      for (int i = 0; i < NUM_VIEWS; i++) begin
        if (commit_q) active_q[i] <= shadow_q[i];
        if (cfg_fire && (cfg_view_in == CFG_W'(i))) shadow_q[i] <= cfg_win;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: hit vector, S2: priority selection, then delay to stage PIPE_DEPTH.
  // ---------------------------------------------------------------------------
  logic [NUM_VIEWS-1:0] hit_d, hit_q;
  logic [SEL_W-1:0]     sel_d;
  logic [SEL_W-1:0]     sel_pipe_q [PIPE_DEPTH-1];  // entry k holds stage k+2

  for (genvar g = 0; g < NUM_VIEWS; g++) begin : g_hit
    window_hit u_hit (
      .win_i (active_q[g]),
      .h_i   (WIN_H_W'(hcount_in)),
      .v_i   (WIN_V_W'(vcount_in)),
      .hit_o (hit_d[g])
    );
  end

  // Scan from the top down so the lowest hitting index is the one left standing.
  always_comb begin
    sel_d = SEL_BG;
    for (int i = NUM_VIEWS - 1; i >= 0; i--) begin
      if (hit_q[i]) sel_d = SEL_W'(i);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_q <= '0;
      for (int s = 0; s < PIPE_DEPTH - 1; s++) sel_pipe_q[s] <= SEL_BG;
    end else begin
      hit_q         <= hit_d;
      sel_pipe_q[0] <= sel_d;
      for (int s = 1; s < PIPE_DEPTH - 1; s++) sel_pipe_q[s] <= sel_pipe_q[s-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Timing delay lines: PIPE_DEPTH stages, output register adds the last one.
  // ---------------------------------------------------------------------------
  logic [PIPE_DEPTH-1:0]          hs_pipe_q, vs_pipe_q, bl_pipe_q;
  logic [PIPE_DEPTH-1:0][H_W-1:0] h_pipe_q;
  logic [PIPE_DEPTH-1:0][V_W-1:0] v_pipe_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      bl_pipe_q <= '1;
      h_pipe_q  <= '0;
      v_pipe_q  <= '0;
    end else begin
      hs_pipe_q <= {hs_pipe_q[PIPE_DEPTH-2:0], hsync_in};
      vs_pipe_q <= {vs_pipe_q[PIPE_DEPTH-2:0], vsync_in};
      bl_pipe_q <= {bl_pipe_q[PIPE_DEPTH-2:0], blank_in};
      h_pipe_q  <= {h_pipe_q[PIPE_DEPTH-2:0], hcount_in};
      v_pipe_q  <= {v_pipe_q[PIPE_DEPTH-2:0], vcount_in};
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: pixel_in is the renderer output for the stage-PIPE_DEPTH count.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] sel_p, sel_out_d;
  logic             bl_p;
  logic [PIX_W-1:0] pix_d;

  assign sel_p = sel_pipe_q[PIPE_DEPTH-2];
  assign bl_p  = bl_pipe_q[PIPE_DEPTH-1];

  always_comb begin
    pix_d     = BG_COLOR;
    sel_out_d = sel_p;
    for (int i = 0; i < NUM_VIEWS; i++) begin
      if (sel_p == SEL_W'(i)) pix_d = pixel_in[i*PIX_W +: PIX_W];
    end
    if (bl_p) begin
      pix_d     = '0;
      sel_out_d = SEL_BG;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_out    <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      blank_out    <= 1'b1;
      hcount_out   <= '0;
      vcount_out   <= '0;
      sel_view_out <= SEL_BG;
    end else begin
      pixel_out    <= pix_d;
      hsync_out    <= hs_pipe_q[PIPE_DEPTH-1];
      vsync_out    <= vs_pipe_q[PIPE_DEPTH-1];
      blank_out    <= bl_p;
      hcount_out   <= h_pipe_q[PIPE_DEPTH-1];
      vcount_out   <= v_pipe_q[PIPE_DEPTH-1];
      sel_view_out <= sel_out_d;
    end
  end

endmodule
